// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction update queue.
//   IDX_W      : bimodal predictor table index width (32-entry table)
//   DEPTH      : default number of in-flight prediction entries
//   bp_entry_t : one queued prediction {table index, predicted taken}
package bp_pkg;

    localparam int unsigned IDX_W = 5;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } bp_entry_t;

endpackage

// File: rtl/bp_update_queue_if.sv
// Bundle of fetch-side, resolve-side and predictor-update signals of bp_update_queue.
//   fetch   : push1/idx1/pred1, push2/idx2/pred2 (slot 2 younger), full (back-pressure)
//   resolve : res_valid, res_taken, flush
//   update  : upd_we, upd_addr, upd_taken, mispredict (registered, one-cycle)
//   status  : count (occupied entries), underflow (sticky)
// master = core side driving fetch/resolve, slave = the queue.
interface bp_update_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             push1;
    logic [IDX_W-1:0] idx1;
    logic             pred1;
    logic             push2;
    logic [IDX_W-1:0] idx2;
    logic             pred2;
    logic             full;
    logic             res_valid;
    logic             res_taken;
    logic             flush;
    logic             upd_we;
    logic [IDX_W-1:0] upd_addr;
    logic             upd_taken;
    logic             mispredict;
    logic [CNT_W-1:0] count;
    logic             underflow;

    modport master (
        output push1, idx1, pred1, push2, idx2, pred2, res_valid, res_taken, flush,
        input  full, upd_we, upd_addr, upd_taken, mispredict, count, underflow
    );

    modport slave (
        input  push1, idx1, pred1, push2, idx2, pred2, res_valid, res_taken, flush,
        output full, upd_we, upd_addr, upd_taken, mispredict, count, underflow
    );

endinterface

// File: rtl/bp_fifo_2w1r.sv
// Circular buffer of predictions: up to two writes and one read per cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push1, wdata1  : enqueue older entry
//   push2, wdata2  : enqueue younger entry (alone if push1 is low)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the buffer; same-cycle pushes are discarded
//   head_entry     : oldest entry (combinational read)
//   count          : occupied entries
//   full           : fewer than two free entries; pushes are then ignored
module bp_fifo_2w1r #(
    parameter int unsigned DEPTH = bp_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push1,
    input  bp_pkg::bp_entry_t        wdata1,
    input  logic                     push2,
    input  bp_pkg::bp_entry_t        wdata2,
    input  logic                     pop,
    input  logic                     flush,
    output bp_pkg::bp_entry_t        head_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    import bp_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] n_push;

    // Conservative: a same-cycle pop does not free room for a push.
    assign full       = count_q > CNT_W'(DEPTH - 2);
    assign count      = count_q;
    assign head_entry = mem[head_q];

    assign push_ok = !full && !flush;
    assign pop_ok  = pop && (count_q != '0);
    assign n_push  = push_ok ? (CNT_W'(push1) + CNT_W'(push2)) : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            tail_d  = tail_q + PTR_W'(n_push);
            count_d = count_q + n_push - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset. A lone push2 takes the slot push1 would have used.
    always_ff @(posedge clk) begin
        if (push_ok && (push1 || push2)) begin
            mem[tail_q] <= push1 ? wdata1 : wdata2;
        end
        if (push_ok && push1 && push2) begin
            mem[tail_q + PTR_W'(1)] <= wdata2;
        end
    end

endmodule

// File: rtl/bp_update_queue.sv
// In-flight branch prediction queue producing bimodal predictor training writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bp_update_queue_if.slave
//                fetch pushes (two slots), full back-pressure,
//                in-order resolve, flush, registered update/mispredict,
//                count and sticky underflow
module bp_update_queue #(
    parameter int unsigned DEPTH = bp_pkg::DEPTH,
    parameter int unsigned IDX_W = bp_pkg::IDX_W
) (
    input logic              clk,
    input logic              rst_n,
    bp_update_queue_if.slave bus
);
    import bp_pkg::*;

    bp_entry_t              wdata1;
    bp_entry_t              wdata2;
    bp_entry_t              head_entry;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   res_fire;

    logic                   upd_we_q;
    logic [IDX_W-1:0]       upd_addr_q;
    logic                   upd_taken_q;
    logic                   mispredict_q;
    logic                   underflow_q;

    assign wdata1   = '{idx: bus.idx1, pred: bus.pred1};
    assign wdata2   = '{idx: bus.idx2, pred: bus.pred2};
    assign res_fire = bus.res_valid && (count != '0);

    bp_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push1      (bus.push1),
        .wdata1     (wdata1),
        .push2      (bus.push2),
        .wdata2     (wdata2),
        .pop        (res_fire),
        .flush      (bus.flush),
        .head_entry (head_entry),
        .count      (count),
        .full       (full)
    );

    // The head is read before the flush takes effect, so a resolve coinciding
    // with a flush still trains the predictor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_we_q     <= 1'b0;
            upd_addr_q   <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            upd_we_q     <= res_fire;
            mispredict_q <= res_fire && (head_entry.pred != bus.res_taken);
            if (res_fire) begin
                upd_addr_q  <= head_entry.idx;
                upd_taken_q <= bus.res_taken;
            end
            if (bus.res_valid && (count == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.full       = full;
    assign bus.count      = count;
    assign bus.upd_we     = upd_we_q;
    assign bus.upd_addr   = upd_addr_q;
    assign bus.upd_taken  = upd_taken_q;
    assign bus.mispredict = mispredict_q;
    assign bus.underflow  = underflow_q;

endmodule
